// File: rtl/mem_pkg.sv
// Shared constants for the memory sink and its upstream controller.
package mem_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int DW_DEFAULT    = 8;

    // Checksum value that, seen at the moment of a dropped byte, raises the bug flag.
    localparam logic [7:0] BUG_CHECKSUM = 8'hA5;

    localparam int COV_FULL      = 0;
    localparam int COV_FULL_PASS = 1;
    localparam int COV_WRAP      = 2;

endpackage

// File: rtl/mem_sink_if.sv
// Handshake bundle between the upstream byte source, the sink FIFO and its consumer.
interface mem_sink_if
    import mem_pkg::*;
#(
    parameter int DW = DW_DEFAULT
);

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          deq_ready;
    logic          deq_valid;
    logic [DW-1:0] deq_data;

    modport master (
        output in_valid,
        output in_data,
        output deq_ready,
        input  deq_valid,
        input  deq_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  deq_ready,
        output deq_valid,
        output deq_data
    );

endinterface

// File: rtl/mem_sink.sv
// Byte sink FIFO for a producer without backpressure: drops on overflow, keeps an
// XOR checksum of accepted bytes and a few sticky coverage / fault flags.
module mem_sink
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DW-1:0]          in_data,
    input  logic                   deq_ready,
    output logic                   deq_valid,
    output logic [DW-1:0]          deq_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DW-1:0]          checksum,
    output logic [2:0]             coverage,
    output logic                   bug
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [DW-1:0] BUG_CMP  = DW'(BUG_CHECKSUM);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] checksum_q, checksum_d;
    logic          overflow_q, overflow_d;
    logic [2:0]    coverage_q, coverage_d;
    logic          bug_q, bug_d;

    logic full_s;
    logic nonempty_s;
    logic deq_fire_s;
    logic enq_fire_s;
    logic drop_s;

    // Handshake qualification; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        full_s     = (count_q == FULL_CNT);
        nonempty_s = (count_q != {CW{1'b0}});
        deq_fire_s = nonempty_s && deq_ready;
        enq_fire_s = in_valid && (!full_s || deq_fire_s);
        drop_s     = in_valid && full_s && !deq_fire_s;
    end

    // Next-state for pointers, occupancy, checksum and sticky flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        checksum_d = checksum_q;
        overflow_d = overflow_q;
        coverage_d = coverage_q;
        bug_d      = bug_q;

        if (enq_fire_s) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            checksum_d = checksum_q ^ in_data;
        end else begin
            wr_ptr_d   = wr_ptr_q;
        end

        if (deq_fire_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({enq_fire_s, deq_fire_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The bug check looks at the checksum as it stood before the dropped byte.
        if (drop_s) begin
            overflow_d = 1'b1;
            bug_d      = bug_q || (checksum_q == BUG_CMP);
        end else begin
            overflow_d = overflow_q;
            bug_d      = bug_q;
        end

        if (count_d == FULL_CNT) begin
            coverage_d[COV_FULL] = 1'b1;
        end else begin
            coverage_d[COV_FULL] = coverage_q[COV_FULL];
        end

        if (enq_fire_s && deq_fire_s && full_s) begin
            coverage_d[COV_FULL_PASS] = 1'b1;
        end else begin
            coverage_d[COV_FULL_PASS] = coverage_q[COV_FULL_PASS];
        end

        if (enq_fire_s && (wr_ptr_q == LAST_IDX)) begin
            coverage_d[COV_WRAP] = 1'b1;
        end else begin
            coverage_d[COV_WRAP] = coverage_q[COV_WRAP];
        end
    end

    // Storage write path; contents survive reset since occupancy alone defines validity.
    always_comb begin
        mem_d = mem_q;
        if (enq_fire_s) begin
            mem_d[wr_ptr_q] = in_data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Control state register with synchronous reset taking priority over traffic.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            checksum_q <= {DW{1'b0}};
            overflow_q <= 1'b0;
            coverage_q <= 3'b000;
            bug_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
            overflow_q <= overflow_d;
            coverage_q <= coverage_d;
            bug_q      <= bug_d;
        end
    end

    // Storage array register.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Head entry is presented combinationally and forced to zero when empty.
    always_comb begin
        deq_valid = nonempty_s;
        if (nonempty_s) begin
            deq_data = mem_q[rd_ptr_q];
        end else begin
            deq_data = {DW{1'b0}};
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign checksum = checksum_q;
    assign coverage = coverage_q;
    assign bug      = bug_q;

endmodule

// File: tb/tb_mem_sink.sv
// Scoreboard bench for mem_sink: a byte queue plus a small flag model, checked every cycle.
module tb_mem_sink;
    import mem_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] count;
    logic       overflow;
    logic [7:0] checksum;
    logic [2:0] coverage;
    logic       bug;

    mem_sink_if #(.DW(8)) bus ();

    mem_sink #(.DEPTH(DEPTH), .DW(8)) dut (
        .clock     (clk),
        .reset     (reset),
        .in_valid  (bus.in_valid),
        .in_data   (bus.in_data),
        .deq_ready (bus.deq_ready),
        .deq_valid (bus.deq_valid),
        .deq_data  (bus.deq_data),
        .count     (count),
        .overflow  (overflow),
        .checksum  (checksum),
        .coverage  (coverage),
        .bug       (bug)
    );

    always #5 clk = ~clk;

    logic [7:0] sb_q [$];
    logic [7:0] m_chk;
    logic       m_ovf;
    logic       m_bug;
    logic [2:0] m_cov;
    int         m_wptr;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_chk  = 8'h00;
        m_ovf  = 1'b0;
        m_bug  = 1'b0;
        m_cov  = 3'b000;
        m_wptr = 0;
    endtask

    // One clock of stimulus: check current outputs against the model, then advance it.
    task automatic step(input logic iv, input logic [7:0] id, input logic dr);
        logic [7:0] head;
        bit         full;
        bit         dfire;
        bit         efire;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.deq_ready = dr;
        #1;
        check("deq_valid", {31'd0, bus.deq_valid}, {31'd0, sb_q.size() != 0});
        check("count", {29'd0, count}, sb_q.size());
        check("checksum", {24'd0, checksum}, {24'd0, m_chk});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("coverage", {29'd0, coverage}, {29'd0, m_cov});
        check("bug", {31'd0, bug}, {31'd0, m_bug});

        full  = (sb_q.size() == DEPTH);
        dfire = dr && (sb_q.size() != 0);
        efire = iv && (!full || dfire);

        if (sb_q.size() == 0) begin
            check("deq_data_empty", {24'd0, bus.deq_data}, 32'd0);
        end else if (dfire) begin
            head = sb_q.pop_front();
            check("deq_pop", {24'd0, bus.deq_data}, {24'd0, head});
        end else begin
            check("deq_head", {24'd0, bus.deq_data}, {24'd0, sb_q[0]});
        end

        if (efire) begin
            sb_q.push_back(id);
            m_chk = m_chk ^ id;
            if (m_wptr == DEPTH - 1) m_cov[2] = 1'b1;
            m_wptr = (m_wptr + 1) % DEPTH;
        end
        if (efire && dfire && full) m_cov[1] = 1'b1;
        if (sb_q.size() == DEPTH) m_cov[0] = 1'b1;
        if (iv && full && !dfire) begin
            m_ovf = 1'b1;
            if (m_chk == BUG_CHECKSUM) m_bug = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // One reset cycle with arbitrary traffic on the inputs, which must be ignored.
    task automatic do_reset(input logic iv, input logic [7:0] id, input logic dr);
        reset         = 1'b1;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.deq_ready = dr;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.deq_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Single byte, then drain it.
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Fill, drop one byte with checksum not at the bug value, then drain.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

        // Full FIFO accepting a byte while the head leaves.
        do_reset(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
        step(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

        // Accepted bytes XOR to A5, then an overflow drop raises bug.
        do_reset(1'b1, 8'hFF, 1'b1);
        step(1'b1, 8'hA0, 1'b0);
        step(1'b1, 8'h05, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Six enqueues interleaved with dequeues wrap the write pointer.
        do_reset(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h10, 1'b0);
        for (int i = 1; i < 6; i++) step(1'b1, 8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1);

        // Reset in the middle of a fill with traffic present.
        do_reset(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        do_reset(1'b1, 8'hEE, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 2) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
